// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR MAC sequencer: state encoding, MAC pipeline
// depth and the default coefficient table.
package fir_seq_pkg;

    localparam int unsigned MAC_LATENCY  = 2;
    localparam int unsigned DRAIN_CYCLES = MAC_LATENCY;
    localparam int unsigned NTAPS_MAX    = 64;
    localparam int unsigned TBL_AW       = $clog2(NTAPS_MAX);
    localparam int unsigned COEF_W       = 16;
    localparam int unsigned ACC_W        = 48;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StDrain,
        StOut
    } seq_state_e;

    typedef logic [NTAPS_MAX-1:0][COEF_W-1:0] coef_tbl_t;

    // Ramp k+1: an impulse walks straight through the taps as 1, 2, 3, ...
    function automatic coef_tbl_t default_coef_table();
        coef_tbl_t t;
        for (int k = 0; k < NTAPS_MAX; k++) begin
            t[k] = COEF_W'(k + 1);
        end
        return t;
    endfunction

    localparam coef_tbl_t COEF_DEFAULT = default_coef_table();

endpackage

// File: rtl/fir_sample_ring.sv
// Circular sample history: one write port, combinational read addressed by tap
// distance from the newest sample, asynchronous clear.
module fir_sample_ring #(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic          clk,
    input  logic          rst_async,
    input  logic          we,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rd_tap,
    output logic [DW-1:0] rd_data
);

    localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);
    localparam logic [AW-1:0] OneAw   = AW'(1);
    localparam logic [AW-1:0] NTapsAw = AW'(NTAPS);

    logic [DW-1:0] mem_q [NTAPS];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_idx;

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_ptr_q <= '0;
            for (int i = 0; i < NTAPS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + OneAw;
        end
    end

    // Newest sample sits at wr_ptr-1; the wrapped sum is < NTAPS so modulo 2^AW is exact.
    always_comb begin
        if (wr_ptr_q > rd_tap) begin
            rd_idx = wr_ptr_q - rd_tap - OneAw;
        end else begin
            rd_idx = wr_ptr_q + NTapsAw - rd_tap - OneAw;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/fir_macc_sequencer.sv
// Control stage feeding a 2-cycle DSP48E MAC: one NTAPS-tap FIR sum per accepted sample.
// Define FIR_SEQ_COEF_WR_EN for a writable coefficient file (coef_* ports).
module fir_macc_sequencer
    import fir_seq_pkg::*;
#(
    parameter int unsigned NTAPS = 16,
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = $clog2(NTAPS)
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_sample,
`ifdef FIR_SEQ_COEF_WR_EN
    input  logic             coef_we,
    input  logic [AW-1:0]    coef_addr,
    input  logic [DW-1:0]    coef_data,
`endif
    output logic [DW-1:0]    mac_a,
    output logic [DW-1:0]    mac_b,
    output logic             mac_clr,
    input  logic [ACC_W-1:0] mac_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data
);

    localparam logic [AW-1:0] LastTap   = AW'(NTAPS - 1);
    localparam logic [AW-1:0] LastDrain = AW'(DRAIN_CYCLES - 1);
    localparam logic [AW-1:0] OneAw     = AW'(1);

    seq_state_e       state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [ACC_W-1:0] out_data_d;
    logic [DW-1:0]    mac_a_d, mac_b_d;
    logic [DW-1:0]    ring_rd, coef_rd;
    logic             mac_clr_d, in_ready_d, out_valid_d;
    logic             accept;

    assign accept = in_valid && in_ready;

    fir_sample_ring #(
        .NTAPS(NTAPS),
        .DW   (DW),
        .AW   (AW)
    ) u_ring (
        .clk      (clk),
        .rst_async(rst_async),
        .we       (accept),
        .wdata    (in_sample),
        .rd_tap   (cnt_d),
        .rd_data  (ring_rd)
    );

`ifdef FIR_SEQ_COEF_WR_EN
    logic [DW-1:0] coef_q [NTAPS];

    // Writes only land in IDLE so a sum in flight always sees one coefficient set.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < NTAPS; i++) begin
                coef_q[i] <= DW'(COEF_DEFAULT[TBL_AW'(i)]);
            end
        end else if (coef_we && (state_q == StIdle)) begin
            coef_q[coef_addr] <= coef_data;
        end
    end

    assign coef_rd = coef_q[cnt_d];
`else
    assign coef_rd = DW'(COEF_DEFAULT[TBL_AW'(cnt_d)]);
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_data_d = out_data;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StRun;
                cnt_d   = '0;
            end
            StRun: begin
                if (cnt_q == LastTap) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + OneAw;
                end
            end
            StDrain: begin
                if (cnt_q == LastDrain) begin
                    state_d    = StOut;
                    out_data_d = mac_acc;
                end else begin
                    cnt_d = cnt_q + OneAw;
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with it cycle for cycle.
    always_comb begin
        mac_a_d     = '0;
        mac_b_d     = '0;
        mac_clr_d   = (state_d == StClear);
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StOut);
        if (state_d == StRun) begin
            mac_a_d = ring_rd;
            mac_b_d = coef_rd;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            in_ready  <= 1'b0;
            mac_clr   <= 1'b1;
            mac_a     <= '0;
            mac_b     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            in_ready  <= in_ready_d;
            mac_clr   <= mac_clr_d;
            mac_a     <= mac_a_d;
            mac_b     <= mac_b_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
        end
    end

endmodule

// File: tb/tb_fir_macc_sequencer.sv
// Bench for fir_macc_sequencer: behavioural 2-cycle MAC plus a shift-register FIR model.
module tb_fir_macc_sequencer;

    localparam int NTAPS  = 16;
    localparam int AW     = $clog2(NTAPS);
    localparam int CLK_T  = 10;

    logic               clk = 1'b0;
    logic               rst_async;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_sample;
    logic signed [15:0] mac_a;
    logic signed [15:0] mac_b;
    logic               mac_clr;
    logic signed [47:0] mac_acc;
    logic signed [31:0] mac_prod;
    logic               out_valid;
    logic               out_ready;
    logic [47:0]        out_data;
`ifdef FIR_SEQ_COEF_WR_EN
    logic               coef_we;
    logic [AW-1:0]      coef_addr;
    logic signed [15:0] coef_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic signed [15:0] hist_m [NTAPS];
    logic signed [15:0] coef_m [NTAPS];
    time                last_acc_t;
    bit                 prev_b2b;

    always #(CLK_T / 2) clk = ~clk;

    fir_macc_sequencer #(
        .NTAPS(NTAPS),
        .DW   (16)
    ) dut (
        .clk      (clk),
        .rst_async(rst_async),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sample(in_sample),
`ifdef FIR_SEQ_COEF_WR_EN
        .coef_we  (coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
`endif
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_clr  (mac_clr),
        .mac_acc  (mac_acc),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    // MAC: product register then accumulator, synchronous clear.
    always @(posedge clk) begin
        if (mac_clr) begin
            mac_prod <= '0;
            mac_acc  <= '0;
        end else begin
            mac_prod <= mac_a * mac_b;
            mac_acc  <= mac_acc + 48'(mac_prod);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            hist_m[k] = '0;
            coef_m[k] = 16'(k + 1);
        end
    endtask

    function automatic logic [47:0] model_sum();
        longint acc;
        acc = 0;
        for (int k = 0; k < NTAPS; k++) begin
            acc += longint'(hist_m[k]) * longint'(coef_m[k]);
        end
        return acc[47:0];
    endfunction

    // Offer one sample, follow it to its output, hold it for `hold` cycles, then release.
    task automatic send(input logic signed [15:0] s, input int hold);
        int          c;
        logic [47:0] exp;
        c = 0;
        while (in_ready !== 1'b1 && c < 50) begin
            tick();
            c++;
        end
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_sample = s;
        out_ready = (hold == 0);
        @(posedge clk);
        for (int k = NTAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = s;
        exp = model_sum();
        if (prev_b2b) check("period", 64'(($time - last_acc_t) / CLK_T), 64'(NTAPS + 5));
        last_acc_t = $time;
        #1;
        // Junk held on the input while busy must never be consumed.
        in_sample = 16'($urandom);
`ifdef FIR_SEQ_COEF_WR_EN
        coef_we   = 1'b1;
        coef_addr = '0;
        coef_data = 16'h7fff;
`endif
        c = 1;
        check("clear_cycle", 64'({in_ready, mac_clr, mac_a, mac_b}), {30'd0, 2'b01, 32'd0});
        while (out_valid !== 1'b1 && c < NTAPS + 30) begin
            tick();
            c++;
        end
        in_valid = 1'b0;
`ifdef FIR_SEQ_COEF_WR_EN
        coef_we = 1'b0;
`endif
        check("latency", 64'(c), 64'(NTAPS + 4));
        check("out_data", 64'(out_data), 64'(exp));
        for (int i = 0; i < hold; i++) begin
            tick();
            check("bp_hold", {13'd0, out_valid, in_ready, out_data, mac_a | mac_b},
                  {13'd0, 1'b1, 1'b0, exp, 16'd0});
        end
        out_ready = 1'b1;
        tick();
        check("release", {62'd0, out_valid, in_ready}, 64'd1);
        prev_b2b = (hold == 0);
    endtask

`ifdef FIR_SEQ_COEF_WR_EN
    task automatic write_coef(input int a, input logic signed [15:0] d);
        coef_we   = 1'b1;
        coef_addr = AW'(a);
        coef_data = d;
        tick();
        coef_we   = 1'b0;
        coef_m[a] = d;
    endtask
`endif

    initial begin
        int          r;
        int          seen;
        logic [15:0] s;
        rst_async = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        out_ready = 1'b0;
        prev_b2b  = 1'b0;
        last_acc_t = 0;
`ifdef FIR_SEQ_COEF_WR_EN
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
`endif
        model_reset();
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data", {16'd0, out_data}, 64'd0);
        check("rst_mac_ab", {32'd0, mac_a, mac_b}, 64'd0);
        check("rst_mac_clr", {63'd0, mac_clr}, 64'd1);
        rst_async = 1'b0;
        #1;
        check("post_rst_mac_clr", {62'd0, mac_clr, in_ready}, 64'd2);
        tick();
        check("first_cycle", {62'd0, mac_clr, in_ready}, 64'd1);

        // Impulse through the default ramp, then zeros until it leaves the window.
        send(16'sd1, 0);
        for (int i = 0; i < NTAPS; i++) send(16'sd0, 0);

        send(16'($urandom), 10);

        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 7);
            s = (r == 0) ? 16'h8000 : (r == 1) ? 16'h7fff : 16'($urandom);
            send(s, $urandom_range(0, 3));
        end

`ifdef FIR_SEQ_COEF_WR_EN
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16'sd1);
        prev_b2b = 1'b0;
        for (int i = 0; i < NTAPS + 2; i++) send(16'sd100, 0);
        write_coef(0, 16'sh8000);
        for (int k = 1; k < NTAPS; k++) write_coef(k, 16'sd0);
        prev_b2b = 1'b0;
        send(16'sh8000, 0);
        check("signed_extreme", {16'd0, out_data}, 64'h0000_0000_4000_0000);
`endif

        // Asynchronous reset pulse in the middle of RUN.
        in_valid  = 1'b1;
        in_sample = 16'sd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst_async = 1'b1;
        #1;
        check("midrst_state", {61'd0, in_ready, out_valid, mac_clr}, 64'd1);
        tick();
        tick();
        rst_async = 1'b0;
        #1;
        check("midrst_release", {62'd0, mac_clr, in_ready}, 64'd2);
        seen = 0;
        for (int i = 0; i < NTAPS + 10; i++) begin
            tick();
            if (out_valid === 1'b1) seen++;
        end
        check("midrst_no_out", 64'(seen), 64'd0);
        model_reset();
        prev_b2b = 1'b0;
        send(16'sd1, 0);
        for (int i = 0; i < 3; i++) send(16'sd0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
